// File: rtl/timing_gen_if.sv
// Raster timing bundle: pixel-advance enable in, counters plus sync/blank/strobe out.
// master = the timing generator, slave = the consumer that supplies ce.
interface timing_gen_if #(
  parameter int HCW = 9,
  parameter int VCW = 8
);
  logic           ce;
  logic [HCW-1:0] hcount;
  logic           hsync;
  logic           hblank_n;
  logic           line_end;
  logic [VCW-1:0] vcount;
  logic           vsync;
  logic           vblank_n;
  logic           frame_end;

  modport master (
    input  ce,
    output hcount, hsync, hblank_n, line_end,
    output vcount, vsync, vblank_n, frame_end
  );

  modport slave (
    output ce,
    input  hcount, hsync, hblank_n, line_end,
    input  vcount, vsync, vblank_n, frame_end
  );
endinterface

// File: rtl/timing_gen.sv
// Raster timing generator with registered sync, blank and end-of-line/frame strobes.
// Define TIMING_GEN_VERT_EN to build the vertical counter; otherwise its outputs are tied off.
module timing_gen #(
  parameter int H_ACTIVE = 200,
  parameter int H_FP     = 10,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 22,
  parameter int V_ACTIVE = 150,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  timing_gen_if.master tg
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);

  localparam logic [HCW-1:0] H_LAST       = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT_END    = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] H_SYNC_START = HCW'(H_ACTIVE + H_FP);
  localparam logic [HCW-1:0] H_SYNC_END   = HCW'(H_ACTIVE + H_FP + H_SYNC);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_param
    $error("timing_gen: every interval parameter must be at least 1");
  end

  // Horizontal path. Every output is registered from the next count value, so
  // each flop describes the count that is visible in the same cycle.
  logic [HCW-1:0] hcount_reg, hcount_next;
  logic           hsync_reg, hsync_next;
  logic           hblank_n_reg, hblank_n_next;
  logic           line_end_reg, line_end_next;
  logic           hwrap;

  logic [VCW-1:0] vcount_out;
  logic           vsync_out;
  logic           vblank_n_out;
  logic           vblank_n_next;
  logic           frame_end_out;

  always_comb begin
    hwrap       = tg.ce && (hcount_reg == H_LAST);
    hcount_next = hcount_reg;
    if (tg.ce) begin
      hcount_next = hwrap ? '0 : hcount_reg + 1'b1;
    end
    // Raised only on the advancing edge into the last pixel, so a ce stall
    // on that pixel keeps the strobe one clock wide.
    line_end_next = tg.ce && (hcount_next == H_LAST);
    hsync_next    = (hcount_next >= H_SYNC_START && hcount_next < H_SYNC_END)
                  ? SYNC_POL : ~SYNC_POL;
    hblank_n_next = (hcount_next < H_ACT_END) && vblank_n_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_reg   <= '0;
      hsync_reg    <= ~SYNC_POL;
      hblank_n_reg <= 1'b1;
      line_end_reg <= 1'b0;
    end else begin
      hcount_reg   <= hcount_next;
      hsync_reg    <= hsync_next;
      hblank_n_reg <= hblank_n_next;
      line_end_reg <= line_end_next;
    end
  end

`ifdef TIMING_GEN_VERT_EN
  localparam logic [VCW-1:0] V_LAST       = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT_END    = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] V_SYNC_START = VCW'(V_ACTIVE + V_FP);
  localparam logic [VCW-1:0] V_SYNC_END   = VCW'(V_ACTIVE + V_FP + V_SYNC);

  logic [VCW-1:0] vcount_reg, vcount_next;
  logic           vsync_reg, vsync_next;
  logic           vblank_n_reg;
  logic           frame_end_reg, frame_end_next;

  // vcount moves on the same edge that wraps hcount, keeping the pair skew-free.
  always_comb begin
    vcount_next = vcount_reg;
    if (hwrap) begin
      vcount_next = (vcount_reg == V_LAST) ? '0 : vcount_reg + 1'b1;
    end
    vblank_n_next  = (vcount_next < V_ACT_END);
    vsync_next     = (vcount_next >= V_SYNC_START && vcount_next < V_SYNC_END)
                   ? SYNC_POL : ~SYNC_POL;
    frame_end_next = line_end_next && (vcount_next == V_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vcount_reg    <= '0;
      vsync_reg     <= ~SYNC_POL;
      vblank_n_reg  <= 1'b1;
      frame_end_reg <= 1'b0;
    end else begin
      vcount_reg    <= vcount_next;
      vsync_reg     <= vsync_next;
      vblank_n_reg  <= vblank_n_next;
      frame_end_reg <= frame_end_next;
    end
  end

  assign vcount_out    = vcount_reg;
  assign vsync_out     = vsync_reg;
  assign vblank_n_out  = vblank_n_reg;
  assign frame_end_out = frame_end_reg;
`else
  assign vblank_n_next = 1'b1;
  assign vcount_out    = '0;
  assign vsync_out     = ~SYNC_POL;
  assign vblank_n_out  = 1'b1;
  assign frame_end_out = 1'b0;
`endif

  assign tg.hcount    = hcount_reg;
  assign tg.hsync     = hsync_reg;
  assign tg.hblank_n  = hblank_n_reg;
  assign tg.line_end  = line_end_reg;
  assign tg.vcount    = vcount_out;
  assign tg.vsync     = vsync_out;
  assign tg.vblank_n  = vblank_n_out;
  assign tg.frame_end = frame_end_out;

endmodule
